tl_router_param: RTL and testbench

- Parametrised transaction-layer router: one input FIFO feeds NUM_PORTS output FIFOs.
- Destination port is taken from the top bits of each word.
- Programmable almost-full/almost-empty thresholds give per-port backpressure.
- Per-port pop counters can be read out in IDLE; the block sits between the link-side push interface and the per-VC consumers.

---
 rtl/tl_router_param_if.sv | 42 ++++
 rtl/tl_router_param.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_router_param.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_router_param_if.sv
// Bus bundle for tl_router_param: link-side push, per-port pop and status,
// threshold configuration and pop-counter readout.
interface tl_router_param_if #(
    parameter int DATA_W    = 12,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 5
);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int CW    = $clog2(DEPTH);

    logic                        init;
    logic [CW-1:0]               Umbral_bajo;
    logic [CW-1:0]               Umbral_alto;
    logic                        pushIn;
    logic [DATA_W-1:0]           dataInputFIFO;
    logic [NUM_PORTS-1:0]        popOut;
    logic [NUM_PORTS*DATA_W-1:0] dataOutput;
    logic [NUM_PORTS-1:0]        validOut;
    logic [NUM_PORTS-1:0]        emptyOut;
    logic [NUM_PORTS-1:0]        almostEmpty;
    logic [NUM_PORTS-1:0]        almostFull;
    logic                        fullIn;
    logic                        req;
    logic [SEL_W-1:0]            idx;
    logic                        counterValid;
    logic [CNT_W-1:0]            counterOut;
    logic                        error;
    logic [2:0]                  state;

    modport master (
        output init, Umbral_bajo, Umbral_alto, pushIn, dataInputFIFO, popOut, req, idx,
        input  dataOutput, validOut, emptyOut, almostEmpty, almostFull, fullIn,
               counterValid, counterOut, error, state
    );

    modport slave (
        input  init, Umbral_bajo, Umbral_alto, pushIn, dataInputFIFO, popOut, req, idx,
        output dataOutput, validOut, emptyOut, almostEmpty, almostFull, fullIn,
               counterValid, counterOut, error, state
    );
endinterface

// File: rtl/tl_router_param.sv
// Transaction-layer router: one input FIFO fans out to NUM_PORTS output FIFOs,
// destination taken from the top SEL_W bits of each word. Almost-full on the
// destination port stalls the input head (no reordering).
// Optional macro TL_BYPASS_EN: a push into an empty input FIFO goes straight to
// its output FIFO when the port has room, cutting latency from 2 to 1.
module tl_router_param #(
    parameter int DATA_W    = 12,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    tl_router_param_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int CW    = $clog2(DEPTH);
    localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] bajo_r, alto_r;
    logic [CW:0]   alto_eff;

    logic [DATA_W-1:0] in_mem [DEPTH];
    logic [CW-1:0]     in_wr, in_rd;
    logic [CW:0]       in_cnt;
    logic              in_full, in_empty;
    logic [DATA_W-1:0] head;
    logic [SEL_W-1:0]  head_dest;

    logic [DATA_W-1:0] out_mem [NUM_PORTS][DEPTH];
    logic [CW-1:0]     out_wr  [NUM_PORTS];
    logic [CW-1:0]     out_rd  [NUM_PORTS];
    logic [CW:0]       out_cnt [NUM_PORTS];
    logic [CNT_W-1:0]  pop_cnt [NUM_PORTS];

    logic [NUM_PORTS-1:0] empty_v, afull_v, aempty_v, pop_ok, wr_hit;
    logic                 xfer_state, xfer, bypass, push_ok, push_bad, pop_bad, illegal, any_busy;
    logic                 wr_valid;
    logic [SEL_W-1:0]     wr_dest;
    logic [DATA_W-1:0]    wr_data;

    logic [NUM_PORTS*DATA_W-1:0] data_q;
    logic [NUM_PORTS-1:0]        valid_q;
    logic                        cval_q, error_q;
    logic [CNT_W-1:0]            cout_q;

    // A captured almost-full threshold of 0 means "only when completely full".
    assign alto_eff = (alto_r == '0) ? FULL_CNT : {1'b0, alto_r};

    // Per-port status flags from occupancy and the captured thresholds.
    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        empty_v  = '0;
        afull_v  = '0;
        aempty_v = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            empty_v[p]  = (out_cnt[p] == '0);
            afull_v[p]  = (out_cnt[p] >= alto_eff);
            aempty_v[p] = (out_cnt[p] <= {1'b0, bajo_r});
        end
    end

    assign in_full    = (in_cnt == FULL_CNT);
    assign in_empty   = (in_cnt == '0);
    assign head       = in_mem[in_rd];
    assign head_dest  = head[DATA_W-1 -: SEL_W];
    assign xfer_state = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign xfer       = xfer_state && !in_empty && !afull_v[head_dest];

`ifdef TL_BYPASS_EN
    logic [SEL_W-1:0] push_dest;
    assign push_dest = bus.dataInputFIFO[DATA_W-1 -: SEL_W];
    assign bypass    = bus.pushIn && xfer_state && in_empty && !afull_v[push_dest];
    assign wr_dest   = bypass ? push_dest : head_dest;
    assign wr_data   = bypass ? bus.dataInputFIFO : head;
`else
    assign bypass    = 1'b0;
    assign wr_dest   = head_dest;
    assign wr_data   = head;
`endif

    // A push at full is only accepted when the head leaves in the same cycle.
    assign push_ok  = bus.pushIn && !bypass && (!in_full || xfer);
    assign push_bad = bus.pushIn && in_full && !xfer;
    assign pop_ok   = bus.popOut & ~empty_v;
    assign pop_bad  = |(bus.popOut & empty_v);
    assign illegal  = push_bad || pop_bad;
    assign wr_valid = xfer || bypass;
    assign any_busy = !in_empty || !(&empty_v);

    // Decode which output FIFO receives the word moving this cycle.
    always_comb begin
        wr_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_hit[p] = wr_valid && (wr_dest == SEL_W'(p));
        end
    end

    // Next-state logic: init and errors override the normal idle/active flow.
    always_comb begin
        state_d = state_q;
        if (state_q == S_RESET) begin
            state_d = S_INIT;
        end else if (bus.init) begin
            state_d = S_INIT;
        end else if (illegal) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_INIT:   state_d = S_IDLE;
                S_IDLE:   if (any_busy)  state_d = S_ACTIVE;
                S_ACTIVE: if (!any_busy) state_d = S_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    // State, thresholds, sticky error and counter readout registers.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            bajo_r  <= '0;
            alto_r  <= CW'(DEPTH - 1);
            error_q <= 1'b0;
            cval_q  <= 1'b0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                bajo_r <= bus.Umbral_bajo;
                alto_r <= bus.Umbral_alto;
            end
            if (bus.init)                           error_q <= 1'b0;
            else if (illegal && state_q != S_RESET) error_q <= 1'b1;
            cval_q <= 1'b0;
            if (bus.req && state_q == S_IDLE) begin
                cval_q <= 1'b1;
                cout_q <= pop_cnt[bus.idx];
            end
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (push_ok) in_wr <= in_wr + 1'b1;
            if (xfer)    in_rd <= in_rd + 1'b1;
            case ({push_ok, xfer})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // Input FIFO storage.
    // NOTE: storage arrays are not reset; the occupancy counters alone define valid entries.
    always_ff @(posedge clk) begin
        if (push_ok) in_mem[in_wr] <= bus.dataInputFIFO;
    end

    // Output FIFO pointers, registered pop data/valid and per-port pop counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_wr[p]  <= '0;
                out_rd[p]  <= '0;
                out_cnt[p] <= '0;
                pop_cnt[p] <= '0;
            end
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_hit[p]) out_wr[p] <= out_wr[p] + 1'b1;
                if (pop_ok[p]) begin
                    out_rd[p]                   <= out_rd[p] + 1'b1;
                    data_q[p*DATA_W +: DATA_W]  <= out_mem[p][out_rd[p]];
                    valid_q[p]                  <= 1'b1;
                    pop_cnt[p]                  <= pop_cnt[p] + 1'b1;
                end
                case ({wr_hit[p], pop_ok[p]})
                    2'b10:   out_cnt[p] <= out_cnt[p] + 1'b1;
                    2'b01:   out_cnt[p] <= out_cnt[p] - 1'b1;
                    default: out_cnt[p] <= out_cnt[p];
                endcase
            end
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_hit[p]) out_mem[p][out_wr[p]] <= wr_data;
        end
    end

    assign bus.dataOutput   = data_q;
    assign bus.validOut     = valid_q;
    assign bus.emptyOut     = empty_v;
    assign bus.almostEmpty  = aempty_v;
    assign bus.almostFull   = afull_v;
    assign bus.fullIn       = in_full;
    assign bus.counterValid = cval_q;
    assign bus.counterOut   = cout_q;
    assign bus.error        = error_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_tl_router_param.sv
// Scoreboard bench for tl_router_param: the stimulus side records expected
// pop data and counter reads in queues; a negedge monitor consumes them.
module tb_tl_router_param;
    localparam int DATA_W    = 12;
    localparam int NUM_PORTS = 4;
    localparam int DEPTH     = 8;
    localparam int CNT_W     = 5;
    localparam int SEL_W     = $clog2(NUM_PORTS);
`ifdef TL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [DATA_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    word_t            model_q   [NUM_PORTS][$];
    word_t            exp_q     [NUM_PORTS][$];
    logic [CNT_W-1:0] cnt_exp_q [$];

    tl_router_param_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    tl_router_param #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input word_t w, input bit accept);
        bus.pushIn        = 1'b1;
        bus.dataInputFIFO = w;
        if (accept) model_q[w[DATA_W-1 -: SEL_W]].push_back(w);
        tick();
        bus.pushIn = 1'b0;
    endtask

    task automatic do_pop(input logic [NUM_PORTS-1:0] m);
        bus.popOut = m;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (m[p]) exp_q[p].push_back(model_q[p].pop_front());
        end
        tick();
        bus.popOut = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.state != 3'd2 && n < 20) begin
            tick();
            n++;
        end
        check(name, bus.state, 3'd2);
    endtask

    // Monitor: compare every pop pulse and counter read against the queues.
    always @(negedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.validOut[p]) begin
                if (exp_q[p].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid p%0d: got data 0x%0h, required no pulse",
                             p, bus.dataOutput[p*DATA_W +: DATA_W]);
                end else begin
                    check($sformatf("pop_data_p%0d", p), bus.dataOutput[p*DATA_W +: DATA_W],
                          exp_q[p].pop_front());
                end
            end
        end
        if (bus.counterValid) begin
            if (cnt_exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_counter: got 0x%0h, required no counterValid", bus.counterOut);
            end else begin
                check("counter_out", bus.counterOut, cnt_exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_PORTS-1:0] m;
        word_t                rw [4];

        reset             = 1'b1;
        bus.init          = 1'b0;
        bus.Umbral_bajo   = 3'd1;
        bus.Umbral_alto   = 3'd6;
        bus.pushIn        = 1'b0;
        bus.dataInputFIFO = '0;
        bus.popOut        = '0;
        bus.req           = 1'b0;
        bus.idx           = '0;

        // Reset and init sequence.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", bus.state, 3'd0);
        check("rst_data", bus.dataOutput, 48'h0);
        check("rst_valid", bus.validOut, 4'h0);
        check("rst_empty", bus.emptyOut, 4'hF);
        check("rst_afull", bus.almostFull, 4'h0);
        check("rst_error", bus.error, 1'b0);
        check("rst_cval", bus.counterValid, 1'b0);
        check("rst_cout", bus.counterOut, 5'd0);
        reset = 1'b0;
        tick();
        check("state_init", bus.state, 3'd1);
        bus.init = 1'b1;
        tick();
        check("state_init_pulse", bus.state, 3'd1);
        bus.init = 1'b0;
        tick();
        check("state_idle", bus.state, 3'd2);
        check("idle_afull", bus.almostFull, 4'h0);
        check("idle_aempty", bus.almostEmpty, 4'hF);

        // Routing: one word per port, two-cycle latency (one with bypass).
        rw[0] = 12'h00F; rw[1] = 12'h414; rw[2] = 12'h819; rw[3] = 12'hC1E;
        for (int i = 0; i < 4; i++) begin
            do_push(rw[i], 1'b1);
            check($sformatf("lat_n_p%0d", i), bus.emptyOut[i], !BYP);
            tick();
            check($sformatf("lat_n1_p%0d", i), bus.emptyOut[i], 1'b0);
            if (i == 0) check("state_active", bus.state, 3'd3);
        end
        do_pop(4'hF);
        check("route_valid", bus.validOut, 4'hF);
        check("route_data", bus.dataOutput, 48'hC1E81941400F);
        check("route_empty", bus.emptyOut, 4'hF);
        tick();
        check("valid_pulse", bus.validOut, 4'h0);
        check("route_idle", bus.state, 3'd2);

        // Backpressure: port 1 stops at 6, port-2 word stuck behind it.
        for (int i = 0; i < 8; i++) do_push(word_t'(12'h410 + i), 1'b1);
        do_push(12'h8A5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_push(word_t'(12'hC30 + i), 1'b1);
            check($sformatf("fullin_fill%0d", i), bus.fullIn, (i == 4));
        end
        check("bp_afull", bus.almostFull, 4'b0010);
        check("bp_hol_empty", bus.emptyOut, 4'b1101);
        check("bp_aempty", bus.almostEmpty, 4'b1101);
        check("bp_no_error", bus.error, 1'b0);
        do_pop(4'b0010);
        check("bp_pop_full", bus.fullIn, 1'b1);
        tick();
        check("bp_resume", bus.fullIn, 1'b0);
        check("bp_refill", bus.almostFull, 4'b0010);

        // Errors: overflow push, then underflow pop, each cleared by init.
        do_push(12'hC40, 1'b1);
        check("err_full_again", bus.fullIn, 1'b1);
        check("err_none_yet", bus.error, 1'b0);
        do_push(12'h0EE, 1'b0);
        check("err_ovf_flag", bus.error, 1'b1);
        check("err_ovf_state", bus.state, 3'd4);
        check("err_ovf_full", bus.fullIn, 1'b1);
        check("err_ovf_p0", bus.emptyOut[0], 1'b1);
        bus.init = 1'b1;
        tick();
        check("err_init_clr", bus.error, 1'b0);
        check("err_init_state", bus.state, 3'd1);
        bus.init = 1'b0;
        tick();
        check("err_back_idle", bus.state, 3'd2);
        bus.popOut = 4'b0001;
        tick();
        bus.popOut = '0;
        check("err_udf_flag", bus.error, 1'b1);
        check("err_udf_state", bus.state, 3'd4);
        check("err_udf_valid", bus.validOut[0], 1'b0);
        check("err_udf_data", bus.dataOutput[DATA_W-1:0], 12'h00F);
        bus.init = 1'b1;
        tick();
        check("err_init_clr2", bus.error, 1'b0);
        bus.init = 1'b0;
        tick();

        // Drain everything; the dropped 0x0EE must never appear.
        for (int c = 0; c < 40; c++) begin
            m = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!bus.emptyOut[p]) begin
                    if (model_q[p].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL drain_extra p%0d: got an unexpected word, required none", p);
                    end else begin
                        m[p] = 1'b1;
                    end
                end
            end
            do_pop(m);
        end
        check("drain_empty", bus.emptyOut, 4'hF);
        check("drain_fullin", bus.fullIn, 1'b0);
        check("drain_state", bus.state, 3'd2);

        // Reset mid-stream clears everything without a clock edge.
        do_push(12'h123, 1'b1);
        tick();
        do_pop(4'b0001);
        tick();
        check("mid_pre_data", bus.dataOutput[DATA_W-1:0], 12'h123);
        do_push(12'h456, 1'b1);
        do_push(12'h789, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_empty", bus.emptyOut, 4'hF);
        check("mid_data", bus.dataOutput, 48'h0);
        check("mid_valid", bus.validOut, 4'h0);
        check("mid_state", bus.state, 3'd0);
        check("mid_fullin", bus.fullIn, 1'b0);
        for (int p = 0; p < NUM_PORTS; p++) model_q[p].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("mid_reinit", bus.state, 3'd1);
        tick();
        check("mid_idle", bus.state, 3'd2);

        // Pop counter wraps: 33 pops on port 3 read back as 1.
        for (int i = 0; i < 33; i++) begin
            do_push(word_t'(12'hC00 + i), 1'b1);
            tick();
            do_pop(4'b1000);
        end
        wait_idle("cnt_wait_idle");
        bus.req = 1'b1;
        bus.idx = 2'd3;
        cnt_exp_q.push_back(5'd1);
        tick();
        bus.req = 1'b0;
        check("cnt_valid", bus.counterValid, 1'b1);
        check("cnt_wrap", bus.counterOut, 5'd1);
        bus.req = 1'b1;
        bus.idx = 2'd0;
        cnt_exp_q.push_back(5'd0);
        tick();
        bus.req = 1'b0;
        tick();
        check("cnt_pulse", bus.counterValid, 1'b0);

        // Counter read while ACTIVE is ignored.
        do_push(12'h0AA, 1'b1);
        tick();
        check("cnt_active", bus.state, 3'd3);
        bus.req = 1'b1;
        bus.idx = 2'd3;
        tick();
        bus.req = 1'b0;
        check("cnt_active_none", bus.counterValid, 1'b0);
        check("cnt_active_hold", bus.counterOut, 5'd0);
        do_pop(4'b0001);
        wait_idle("final_idle");
        tick();

        for (int p = 0; p < NUM_PORTS; p++) begin
            check($sformatf("model_left_p%0d", p), model_q[p].size(), 0);
            check($sformatf("exp_left_p%0d", p), exp_q[p].size(), 0);
        end
        check("cnt_exp_left", cnt_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
